pit_table_v2: RTL

PIT_TABLE_V2 -- requirements
Module: pit_table_v2

---
 rtl/pit_table_v2.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pit_table_v2.sv
// Pending Interest Table: one hashed slot per name prefix, single-port RAM,
// INIT/IDLE/READ/DECIDE/RESP sequencer.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   tick              advance the "now" timestamp by one
//   req_valid/ready   request handshake; one request in flight at most
//   req_is_data       1 = Data, 0 = Interest
//   req_prefix        name prefix
//   req_face          arrival face
//   resp_valid        one-cycle strobe, three cycles after accept
//   resp_code         0 FORWARD, 1 AGGREGATE, 2 SATISFIED, 3 REJECT
//   resp_faces        pending face mask on SATISFIED, zero otherwise
//   resp_index        hashed slot of the request
//   occupancy         count of valid entries
module pit_table_v2 #(
  parameter int PREFIX_W = 64,
  parameter int ADDR_W   = 10,
  parameter int FACES    = 4,
  parameter int TS_W     = 16,
  parameter int LIFETIME = 1000,
  localparam int FW      = (FACES > 1) ? $clog2(FACES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_data,
  input  logic [PREFIX_W-1:0] req_prefix,
  input  logic [FW-1:0]       req_face,
  output logic                resp_valid,
  output logic [1:0]          resp_code,
  output logic [FACES-1:0]    resp_faces,
  output logic [ADDR_W-1:0]   resp_index,
  output logic [ADDR_W:0]     occupancy
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NCHUNK = (PREFIX_W + ADDR_W - 1) / ADDR_W;
  localparam int PADW   = NCHUNK * ADDR_W;

  localparam logic [TS_W-1:0] LIFE    = TS_W'(LIFETIME);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] C_FWD = 2'd0;
  localparam logic [1:0] C_AGG = 2'd1;
  localparam logic [1:0] C_SAT = 2'd2;
  localparam logic [1:0] C_REJ = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_DECIDE,
    S_RESP
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] tag;
    logic [FACES-1:0]    faces;
    logic [TS_W-1:0]     stamp;
  } entry_t;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic [TS_W-1:0]     now_q, now_d;
  logic [ADDR_W:0]     occ_q, occ_d;
  logic                is_data_q, is_data_d;
  logic [PREFIX_W-1:0] prefix_q, prefix_d;
  logic [FW-1:0]       face_q, face_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                resp_valid_q, resp_valid_d;
  logic [1:0]          resp_code_q, resp_code_d;
  logic [FACES-1:0]    resp_faces_q, resp_faces_d;

  entry_t              mem [DEPTH];
  entry_t              rd_q;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  entry_t              ram_wdata;

  logic [PADW-1:0]     pad;
  logic [ADDR_W-1:0]   hash;
  logic [TS_W-1:0]     age;
  logic                live;
  logic                tag_hit;
  logic [FACES-1:0]    face_bit;

  // Single-port RAM, read-first, one-cycle read latency.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_q <= mem[ram_addr];
  end

  // XOR-fold of the prefix, last chunk zero-padded.
  always_comb begin
    pad  = PADW'(req_prefix);
    hash = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      hash = hash ^ pad[i*ADDR_W +: ADDR_W];
    end
  end

  // Age is modular, so a wrap of "now" still gives the true distance.
  always_comb begin
    age      = now_q - rd_q.stamp;
    live     = rd_q.valid && (age < LIFE);
    tag_hit  = (rd_q.tag == prefix_q);
    face_bit = FACES'(1) << face_q;
  end

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    now_d        = tick ? now_q + 1'b1 : now_q;
    occ_d        = occ_q;
    is_data_d    = is_data_q;
    prefix_d     = prefix_q;
    face_d       = face_q;
    idx_d        = idx_q;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    resp_faces_d = resp_faces_q;
    ram_we       = 1'b0;
    ram_addr     = idx_q;
    ram_wdata    = '0;

    unique case (state_q)
      S_INIT: begin
        ram_we      = 1'b1;
        ram_addr    = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (&init_addr_q) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (req_valid) begin
          is_data_d = req_is_data;
          prefix_d  = req_prefix;
          face_d    = req_face;
          idx_d     = hash;
          state_d   = S_READ;
        end
      end

      S_READ: begin
        state_d = S_DECIDE;
      end

      S_DECIDE: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_faces_d = '0;
        resp_code_d  = C_REJ;
        if (!is_data_d) begin
          unique case (1'b1)
            live && tag_hit: begin
              ram_we          = 1'b1;
              ram_wdata       = rd_q;
              ram_wdata.faces = rd_q.faces | face_bit;
              ram_wdata.stamp = now_q;
              resp_code_d     = C_AGG;
            end
            !rd_q.valid: begin
              ram_we          = 1'b1;
              ram_wdata.valid = 1'b1;
              ram_wdata.tag   = prefix_q;
              ram_wdata.faces = face_bit;
              ram_wdata.stamp = now_q;
              resp_code_d     = C_FWD;
              if (occ_q < DEPTH_C) begin
                occ_d = occ_q + 1'b1;
              end
            end
            rd_q.valid && !live: begin
              ram_we          = 1'b1;
              ram_wdata.valid = 1'b1;
              ram_wdata.tag   = prefix_q;
              ram_wdata.faces = face_bit;
              ram_wdata.stamp = now_q;
              resp_code_d     = C_FWD;
            end
            live && !tag_hit: begin
              resp_code_d = C_REJ;
            end
          endcase
        end else begin
          unique case (1'b1)
            live && tag_hit: begin
              ram_we          = 1'b1;
              ram_wdata       = rd_q;
              ram_wdata.valid = 1'b0;
              resp_code_d     = C_SAT;
              resp_faces_d    = rd_q.faces;
              if (occ_q != '0) begin
                occ_d = occ_q - 1'b1;
              end
            end
            rd_q.valid && !live && tag_hit: begin
              ram_we          = 1'b1;
              ram_wdata       = rd_q;
              ram_wdata.valid = 1'b0;
              resp_code_d     = C_REJ;
              if (occ_q != '0) begin
                occ_d = occ_q - 1'b1;
              end
            end
            default: begin
              resp_code_d = C_REJ;
            end
          endcase
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      init_addr_q  <= '0;
      now_q        <= '0;
      occ_q        <= '0;
      is_data_q    <= 1'b0;
      prefix_q     <= '0;
      face_q       <= '0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      resp_faces_q <= '0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      now_q        <= now_d;
      occ_q        <= occ_d;
      is_data_q    <= is_data_d;
      prefix_q     <= prefix_d;
      face_q       <= face_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      resp_faces_q <= resp_faces_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_code  = resp_code_q;
  assign resp_faces = resp_faces_q;
  assign resp_index = idx_q;
  assign occupancy  = occ_q;

endmodule
